// File: rtl/dmem_bus_bridge_pkg.sv
// rtl/dmem_bus_bridge_pkg.sv - shared types for the data-memory bus bridge
package mem_types;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ALIGN   = 2'b01,
    FC_BUS     = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } bridge_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - size/alignment check, byte enables, write lane steering, load right-align
module dmem_lane_align
  import mem_types::*;
(
  input  logic [1:0]  i_req_addr_lo,
  input  logic [2:0]  i_req_mode,
  input  logic        i_req_we,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_legal,
  output logic [3:0]  o_req_be,
  output logic [31:0] o_req_wdata,
  input  logic [1:0]  i_rsp_addr_lo,
  input  logic [2:0]  i_rsp_mode,
  input  logic [31:0] i_rsp_rdata,
  output logic [31:0] o_rsp_data
);

  logic [31:0] w_byte_shift;
  logic [31:0] w_half_shift;

  assign w_byte_shift = i_rsp_rdata >> {i_rsp_addr_lo, 3'b000};
  assign w_half_shift = i_rsp_rdata >> {i_rsp_addr_lo[1], 4'b0000};

  // Stores only know B/H/W; the unsigned codes are load-only.
  always_comb begin
    o_req_legal = 1'b0;
    o_req_be    = 4'b0000;
    o_req_wdata = 32'h0;
    case (i_req_mode)
      SZ_B: begin
        o_req_legal = 1'b1;
        o_req_be    = 4'b0001 << i_req_addr_lo;
        o_req_wdata = {4{i_req_wdata[7:0]}};
      end
      SZ_H: begin
        o_req_legal = ~i_req_addr_lo[0];
        o_req_be    = 4'b0011 << i_req_addr_lo;
        o_req_wdata = {2{i_req_wdata[15:0]}};
      end
      SZ_W: begin
        o_req_legal = (i_req_addr_lo == 2'b00);
        o_req_be    = 4'b1111;
        o_req_wdata = i_req_wdata;
      end
      SZ_BU: begin
        o_req_legal = ~i_req_we;
        o_req_be    = 4'b0001 << i_req_addr_lo;
      end
      SZ_HU: begin
        o_req_legal = ~i_req_we & ~i_req_addr_lo[0];
        o_req_be    = 4'b0011 << i_req_addr_lo;
      end
      default: o_req_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_rsp_data = 32'h0;
    case (i_rsp_mode)
      SZ_B, SZ_BU: o_rsp_data = {24'h0, w_byte_shift[7:0]};
      SZ_H, SZ_HU: o_rsp_data = {16'h0, w_half_shift[15:0]};
      SZ_W:        o_rsp_data = i_rsp_rdata;
      default:     o_rsp_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - core dmem port to req/gnt/rvalid bus bridge with fault reporting
module dmem_bus_bridge
  import mem_types::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  output logic        dmem_fault,
  output logic [1:0]  dmem_fault_cause,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_t r_state;
  fault_cause_t  r_cause;
  logic [31:0]   r_addr;
  logic          r_we;
  logic [2:0]    r_mode;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic          r_fault;
  logic [31:0]   r_rdata;

  logic [2:0]  w_mode;
  logic        w_accept;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rsp_data;
  logic        w_timeout;

  assign w_mode    = dmem_write_enable ? dmem_write_mode : dmem_read_mode;
  assign w_accept  = (r_state == ST_IDLE) & dmem_enable & (dmem_write_enable | dmem_read_enable);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);

  dmem_lane_align u_align (
    .i_req_addr_lo (dmem_address[1:0]),
    .i_req_mode    (w_mode),
    .i_req_we      (dmem_write_enable),
    .i_req_wdata   (dmem_write_data),
    .o_req_legal   (w_legal),
    .o_req_be      (w_be),
    .o_req_wdata   (w_wdata),
    .i_rsp_addr_lo (r_addr[1:0]),
    .i_rsp_mode    (r_mode),
    .i_rsp_rdata   (bus_rdata),
    .o_rsp_data    (w_rsp_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cause <= FC_NONE;
      r_addr  <= 32'h0;
      r_we    <= 1'b0;
      r_mode  <= 3'b000;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            if (w_legal) begin
              r_state <= ST_REQ;
              r_addr  <= dmem_address;
              r_we    <= dmem_write_enable;
              r_mode  <= w_mode;
              r_be    <= w_be;
              r_wdata <= w_wdata;
            end else begin
              r_fault <= 1'b1;
              r_cause <= FC_ALIGN;
              r_rdata <= 32'h0;
            end
          end
        end
        // A response arriving before the grant is a protocol violation and is dropped.
        ST_REQ: begin
          if (w_timeout) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b1;
            r_cause <= FC_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (bus_gnt) r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus_rvalid) begin
            r_state <= ST_IDLE;
            if (bus_err) begin
              r_fault <= 1'b1;
              r_cause <= FC_BUS;
              r_rdata <= 32'h0;
            end else if (!r_we) begin
              r_rdata <= w_rsp_data;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b1;
            r_cause <= FC_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_wait        = (r_state != ST_IDLE);
  assign bus_req          = (r_state == ST_REQ);
  assign bus_addr         = {r_addr[31:2], 2'b00};
  assign bus_we           = r_we;
  assign bus_be           = r_be;
  assign bus_wdata        = r_wdata;
  assign dmem_read_data   = r_rdata;
  assign dmem_fault       = r_fault;
  assign dmem_fault_cause = r_cause;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - scoreboard bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dmem_address;
  logic        dmem_enable;
  logic [31:0] dmem_write_data;
  logic        dmem_write_enable;
  logic [2:0]  dmem_write_mode;
  logic        dmem_read_enable;
  logic [2:0]  dmem_read_mode;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic        dmem_fault;
  logic [1:0]  dmem_fault_cause;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  cause;
  } res_exp_t;

  bus_exp_t q_bus[$];
  res_exp_t q_res[$];

  always #5 clk = ~clk;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .dmem_address      (dmem_address),
    .dmem_enable       (dmem_enable),
    .dmem_write_data   (dmem_write_data),
    .dmem_write_enable (dmem_write_enable),
    .dmem_write_mode   (dmem_write_mode),
    .dmem_read_enable  (dmem_read_enable),
    .dmem_read_mode    (dmem_read_mode),
    .dmem_read_data    (dmem_read_data),
    .dmem_wait         (dmem_wait),
    .dmem_fault        (dmem_fault),
    .dmem_fault_cause  (dmem_fault_cause),
    .bus_req           (bus_req),
    .bus_addr          (bus_addr),
    .bus_we            (bus_we),
    .bus_be            (bus_be),
    .bus_wdata         (bus_wdata),
    .bus_gnt           (bus_gnt),
    .bus_rvalid        (bus_rvalid),
    .bus_rdata         (bus_rdata),
    .bus_err           (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] mode, input logic [1:0] a);
    case (mode[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic drive_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                           input logic [31:0] data);
    dmem_enable       = 1'b1;
    dmem_address      = addr;
    dmem_write_data   = data;
    dmem_write_enable = we;
    dmem_read_enable  = ~we;
    dmem_write_mode   = mode;
    dmem_read_mode    = mode;
    tick();
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    dmem_read_enable  = 1'b0;
  endtask

  task automatic pop_res(input string tag);
    res_exp_t e;
    if (q_res.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = q_res.pop_front();
      check({tag, "_rdata"}, dmem_read_data, e.rdata);
      check({tag, "_fault"}, {31'h0, dmem_fault}, {31'h0, e.cause != 2'b00});
      if (e.cause != 2'b00) check({tag, "_cause"}, {30'h0, dmem_fault_cause}, {30'h0, e.cause});
    end
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rsp, input logic err, input int gnt_dly,
                         input logic [31:0] exp_rd, input logic [1:0] exp_cause);
    bus_exp_t b;
    res_exp_t r;
    int waits;
    b.addr  = {addr[31:2], 2'b00};
    b.we    = we;
    b.be    = model_be(mode, addr[1:0]);
    b.wdata = (mode == 3'b010) ? data : (data << (8 * addr[1:0]));
    q_bus.push_back(b);
    r.rdata = exp_rd;
    r.cause = exp_cause;
    q_res.push_back(r);
    drive_req(we, mode, addr, data);
    waits = 0;
    for (int i = 0; i < gnt_dly; i++) begin
      if (dmem_wait) waits++;
      check({tag, "_req_held"}, {31'h0, bus_req}, 32'd1);
      tick();
    end
    check({tag, "_req"}, {31'h0, bus_req}, 32'd1);
    b = q_bus.pop_front();
    check({tag, "_addr"}, bus_addr, b.addr);
    check({tag, "_we"}, {31'h0, bus_we}, {31'h0, b.we});
    check({tag, "_be"}, {28'h0, bus_be}, {28'h0, b.be});
    if (b.we) check({tag, "_wdata"}, bus_wdata & lane_mask(b.be), b.wdata & lane_mask(b.be));
    if (dmem_wait) waits++;
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'h0, bus_req}, 32'd0);
    if (dmem_wait) waits++;
    bus_rvalid = 1'b1;
    bus_rdata  = rsp;
    bus_err    = err;
    tick();
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    check({tag, "_wait_cycles"}, waits, gnt_dly + 2);
    check({tag, "_wait_low"}, {31'h0, dmem_wait}, 32'd0);
    pop_res(tag);
    tick();
    check({tag, "_fault_clr"}, {31'h0, dmem_fault}, 32'd0);
  endtask

  task automatic bad_req(input string tag, input logic we, input logic [2:0] mode,
                         input logic [31:0] addr);
    res_exp_t r;
    r.rdata = 32'h0;
    r.cause = 2'b01;
    q_res.push_back(r);
    drive_req(we, mode, addr, 32'hFFFF_FFFF);
    check({tag, "_no_req"}, {31'h0, bus_req}, 32'd0);
    check({tag, "_no_wait"}, {31'h0, dmem_wait}, 32'd0);
    pop_res(tag);
    tick();
    check({tag, "_fault_clr"}, {31'h0, dmem_fault}, 32'd0);
  endtask

  initial begin
    int cnt;
    res_exp_t r;
    reset_n = 1'b0;
    dmem_address = 32'h0; dmem_enable = 1'b0; dmem_write_data = 32'h0;
    dmem_write_enable = 1'b0; dmem_write_mode = 3'b0;
    dmem_read_enable = 1'b0; dmem_read_mode = 3'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_req", {31'h0, bus_req}, 32'd0);
    check("rst_wait", {31'h0, dmem_wait}, 32'd0);
    check("rst_rdata", dmem_read_data, 32'h0);
    check("rst_fault", {31'h0, dmem_fault}, 32'd0);
    check("rst_cause", {30'h0, dmem_fault_cause}, 32'd0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", {28'h0, bus_be}, 32'd0);

    run_txn("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 2'b00);
    run_txn("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'hAABBCCDD, 1'b0, 1, 32'h000000AA, 2'b00);
    run_txn("lb101", 1'b0, 3'b000, 32'h101, 32'h0, 32'hAABBCCDD, 1'b0, 0, 32'h000000CC, 2'b00);
    run_txn("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hAABBCCDD, 1'b0, 2, 32'h0000AABB, 2'b00);
    run_txn("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, 32'hAABB8001, 1'b0, 0, 32'h00008001, 2'b00);
    run_txn("sb201", 1'b1, 3'b000, 32'h201, 32'h5A, 32'h0, 1'b0, 3, 32'h00008001, 2'b00);
    run_txn("sh202", 1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 1'b0, 0, 32'h00008001, 2'b00);
    run_txn("sw300", 1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 1'b0, 1, 32'h00008001, 2'b00);

    bad_req("lw_mis", 1'b0, 3'b010, 32'h102);
    bad_req("lmode011", 1'b0, 3'b011, 32'h100);
    bad_req("sh_mis", 1'b1, 3'b001, 32'h201);

    run_txn("lw500", 1'b0, 3'b010, 32'h500, 32'h0, 32'h13579BDF, 1'b0, 0, 32'h13579BDF, 2'b00);

    r.rdata = 32'h13579BDF;
    r.cause = 2'b11;
    q_res.push_back(r);
    drive_req(1'b0, 3'b010, 32'h400, 32'h0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req) break;
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, 8);
    check("to_wait", {31'h0, dmem_wait}, 32'd0);
    pop_res("to");
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFFFFFF;
    tick();
    bus_rvalid = 1'b0;
    check("to_late_rdata", dmem_read_data, 32'h13579BDF);
    check("to_late_wait", {31'h0, dmem_wait}, 32'd0);
    check("to_late_fault", {31'h0, dmem_fault}, 32'd0);

    run_txn("buserr", 1'b0, 3'b010, 32'h600, 32'h0, 32'h77777777, 1'b1, 0, 32'h0, 2'b10);

    run_txn("lw700", 1'b0, 3'b010, 32'h700, 32'h0, 32'h2468ACE0, 1'b0, 0, 32'h2468ACE0, 2'b00);
    drive_req(1'b0, 3'b010, 32'h704, 32'h0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check("mid_resp_wait", {31'h0, dmem_wait}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mrst_wait", {31'h0, dmem_wait}, 32'd0);
    check("mrst_req", {31'h0, bus_req}, 32'd0);
    check("mrst_rdata", dmem_read_data, 32'h0);
    check("mrst_addr", bus_addr, 32'h0);
    check("mrst_cause", {30'h0, dmem_fault_cause}, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h99;
    tick();
    bus_rvalid = 1'b0;
    check("mrst_late_rdata", dmem_read_data, 32'h0);
    check("mrst_late_wait", {31'h0, dmem_wait}, 32'd0);

    run_txn("lw800", 1'b0, 3'b010, 32'h800, 32'h0, 32'hCAFEF00D, 1'b0, 0, 32'hCAFEF00D, 2'b00);
    dmem_enable      = 1'b0;
    dmem_read_enable = 1'b1;
    dmem_read_mode   = 3'b010;
    dmem_address     = 32'h804;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", {31'h0, bus_req}, 32'd0);
      check("stall_wait", {31'h0, dmem_wait}, 32'd0);
      check("stall_rdata", dmem_read_data, 32'hCAFEF00D);
    end
    dmem_read_enable = 1'b0;
    check("q_drained", q_res.size() + q_bus.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
